// File: rtl/neural_pkg.sv
// Shared definitions for the neural datapath, its controller and the
// wide operand memory block.
//   LANES : number of parallel multiply lanes per chunk
//   WIDTH : accumulator width in bits
//   FRAC  : fractional bits of the 8-bit fixed-point format (64 == 1.0)
//   data_t: signed 8-bit activation / weight / result word
//   prod_t: full-precision signed product of two data_t words
package neural_pkg;

    localparam int LANES = 50;
    localparam int WIDTH = 32;
    localparam int FRAC  = 6;

    typedef logic signed [7:0]  data_t;
    typedef logic signed [15:0] prod_t;

endpackage : neural_pkg

// File: rtl/neural_dot_tree.sv
// dot_tree: combinational dot product of LANES operand pairs.
// Each lane forms a full 16-bit signed product. The product is then
// sign-extended to WIDTH. A balanced binary adder tree sums the lanes.
// The lane count is padded with zero leaves up to a power of two.
//   x, w : LANES signed 8-bit operands
//   dot  : WIDTH-bit signed sum of x[k]*w[k]
module dot_tree
    import neural_pkg::*;
#(
    parameter int LANES = neural_pkg::LANES,
    parameter int WIDTH = neural_pkg::WIDTH
) (
    input  data_t                    x [LANES],
    input  data_t                    w [LANES],
    output logic signed [WIDTH-1:0]  dot
);

    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NPAD   = 1 << LEVELS;

    genvar gl, gi;
    generate
        for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
            localparam int CNT = NPAD >> gl;
            logic signed [WIDTH-1:0] s [CNT];

            if (gl == 0) begin : g_leaf
                for (gi = 0; gi < CNT; gi++) begin : g_lane
                    if (gi < LANES) begin : g_mul
                        prod_t p;
                        assign p     = x[gi] * w[gi];
                        assign s[gi] = {{(WIDTH-16){p[15]}}, p};
                    end else begin : g_pad
                        assign s[gi] = '0;
                    end
                end
            end else begin : g_node
                for (gi = 0; gi < CNT; gi++) begin : g_add
                    assign s[gi] = g_lvl[gl-1].s[2*gi] + g_lvl[gl-1].s[2*gi+1];
                end
            end
        end
    endgenerate

    assign dot = g_lvl[LEVELS].s[0];

endmodule : dot_tree

// File: rtl/neural.sv
// neural: chunked fixed-point neuron.
// Each clock it adds one LANES-wide dot product chunk into a WIDTH-bit
// accumulator. A zero strobe loads the accumulator instead of adding to it.
// On the isbias (last) chunk, the activated result is registered:
// it is 0 if the sum is negative, else min(sum >>> FRAC, 127).
// The bias is carried as an ordinary lane pair (x = 1.0, w = bias).
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset (clears acc and output)
//   zero         : first-chunk strobe (load instead of accumulate)
//   fb           : feedback port from output_data, functionally unused
//   isbias       : last-chunk strobe (accumulate, then register result)
//   x1..x50      : activation operands
//   w1..w50      : weight operands
//   output_data  : registered activated neuron result
module neural
    import neural_pkg::*;
#(
    parameter int LANES = neural_pkg::LANES,
    parameter int WIDTH = neural_pkg::WIDTH,
    parameter int FRAC  = neural_pkg::FRAC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic [7:0]  fb,
    input  logic        isbias,
    input  data_t       x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,  x10,
    input  data_t       x11, x12, x13, x14, x15, x16, x17, x18, x19, x20,
    input  data_t       x21, x22, x23, x24, x25, x26, x27, x28, x29, x30,
    input  data_t       x31, x32, x33, x34, x35, x36, x37, x38, x39, x40,
    input  data_t       x41, x42, x43, x44, x45, x46, x47, x48, x49, x50,
    input  data_t       w1,  w2,  w3,  w4,  w5,  w6,  w7,  w8,  w9,  w10,
    input  data_t       w11, w12, w13, w14, w15, w16, w17, w18, w19, w20,
    input  data_t       w21, w22, w23, w24, w25, w26, w27, w28, w29, w30,
    input  data_t       w31, w32, w33, w34, w35, w36, w37, w38, w39, w40,
    input  data_t       w41, w42, w43, w44, w45, w46, w47, w48, w49, w50,
    output logic [7:0]  output_data
);

    // The feedback loop exists only for the integrator's wiring; it is
    // folded into a dead signal so it has no effect on the datapath.
    logic unused_fb;
    assign unused_fb = ^fb;

    // Flatten the discrete ports so lanes can be indexed in a generate loop.
    logic [8*50-1:0] x_flat, w_flat;
    assign x_flat = {x50, x49, x48, x47, x46, x45, x44, x43, x42, x41,
                     x40, x39, x38, x37, x36, x35, x34, x33, x32, x31,
                     x30, x29, x28, x27, x26, x25, x24, x23, x22, x21,
                     x20, x19, x18, x17, x16, x15, x14, x13, x12, x11,
                     x10, x9,  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1};
    assign w_flat = {w50, w49, w48, w47, w46, w45, w44, w43, w42, w41,
                     w40, w39, w38, w37, w36, w35, w34, w33, w32, w31,
                     w30, w29, w28, w27, w26, w25, w24, w23, w22, w21,
                     w20, w19, w18, w17, w16, w15, w14, w13, w12, w11,
                     w10, w9,  w8,  w7,  w6,  w5,  w4,  w3,  w2,  w1};

    data_t x_arr [LANES];
    data_t w_arr [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign x_arr[gi] = x_flat[8*gi +: 8];
            assign w_arr[gi] = w_flat[8*gi +: 8];
        end
    endgenerate

    logic signed [WIDTH-1:0] dot;

    dot_tree #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_dot_tree (
        .x   (x_arr),
        .w   (w_arr),
        .dot (dot)
    );

    logic signed [WIDTH-1:0] acc_reg, acc_next;
    logic signed [WIDTH-1:0] shifted;
    logic [7:0]              act_next;

    // The activation works on the post-edge accumulator value. This way a
    // combined zero+isbias chunk produces its result from that dot alone.
    always_comb begin
        acc_next = zero ? dot : acc_reg + dot;
        shifted  = acc_next >>> FRAC;
        act_next = 8'd0;
        if (acc_next[WIDTH-1]) begin
            act_next = 8'd0;
        end else if (shifted > $signed(WIDTH'(127))) begin
            act_next = 8'd127;
        end else begin
            act_next = shifted[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg     <= '0;
            output_data <= '0;
        end else begin
            acc_reg <= acc_next;
            if (isbias) begin
                output_data <= act_next;
            end
        end
    end

endmodule : neural

// File: tb/tb_neural.sv
module tb_neural;

    logic              clk = 1'b0;
    logic              reset;
    logic              zero;
    logic              isbias;
    logic [7:0]        fb;
    logic signed [7:0] xv [50];
    logic signed [7:0] wv [50];
    logic [7:0]        output_data;

    int vectors = 0;
    int miscompares = 0;
    int model_acc = 0;
    int model_out = 0;
    int exp_q [$];

    always #5 clk = ~clk;
    assign fb = output_data;

    neural dut (
        .clk(clk), .reset(reset), .zero(zero), .fb(fb), .isbias(isbias),
        .x1(xv[0]),   .x2(xv[1]),   .x3(xv[2]),   .x4(xv[3]),   .x5(xv[4]),
        .x6(xv[5]),   .x7(xv[6]),   .x8(xv[7]),   .x9(xv[8]),   .x10(xv[9]),
        .x11(xv[10]), .x12(xv[11]), .x13(xv[12]), .x14(xv[13]), .x15(xv[14]),
        .x16(xv[15]), .x17(xv[16]), .x18(xv[17]), .x19(xv[18]), .x20(xv[19]),
        .x21(xv[20]), .x22(xv[21]), .x23(xv[22]), .x24(xv[23]), .x25(xv[24]),
        .x26(xv[25]), .x27(xv[26]), .x28(xv[27]), .x29(xv[28]), .x30(xv[29]),
        .x31(xv[30]), .x32(xv[31]), .x33(xv[32]), .x34(xv[33]), .x35(xv[34]),
        .x36(xv[35]), .x37(xv[36]), .x38(xv[37]), .x39(xv[38]), .x40(xv[39]),
        .x41(xv[40]), .x42(xv[41]), .x43(xv[42]), .x44(xv[43]), .x45(xv[44]),
        .x46(xv[45]), .x47(xv[46]), .x48(xv[47]), .x49(xv[48]), .x50(xv[49]),
        .w1(wv[0]),   .w2(wv[1]),   .w3(wv[2]),   .w4(wv[3]),   .w5(wv[4]),
        .w6(wv[5]),   .w7(wv[6]),   .w8(wv[7]),   .w9(wv[8]),   .w10(wv[9]),
        .w11(wv[10]), .w12(wv[11]), .w13(wv[12]), .w14(wv[13]), .w15(wv[14]),
        .w16(wv[15]), .w17(wv[16]), .w18(wv[17]), .w19(wv[18]), .w20(wv[19]),
        .w21(wv[20]), .w22(wv[21]), .w23(wv[22]), .w24(wv[23]), .w25(wv[24]),
        .w26(wv[25]), .w27(wv[26]), .w28(wv[27]), .w29(wv[28]), .w30(wv[29]),
        .w31(wv[30]), .w32(wv[31]), .w33(wv[32]), .w34(wv[33]), .w35(wv[34]),
        .w36(wv[35]), .w37(wv[36]), .w38(wv[37]), .w39(wv[38]), .w40(wv[39]),
        .w41(wv[40]), .w42(wv[41]), .w43(wv[42]), .w44(wv[43]), .w45(wv[44]),
        .w46(wv[45]), .w47(wv[46]), .w48(wv[47]), .w49(wv[48]), .w50(wv[49]),
        .output_data(output_data)
    );

    // Reference activation: ReLU, then drop FRAC bits, then saturate at 127.
    function automatic int act(input int s);
        int v;
        if (s < 0) return 0;
        v = s >>> 6;
        return (v > 127) ? 127 : v;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
        $display("check %-10s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < 50; k++) begin
            xv[k] = 8'sd0;
            wv[k] = 8'sd0;
        end
    endtask

    // Apply one chunk with the lanes already set up. The model and scoreboard
    // are updated, then one edge is taken and the results are checked.
    task automatic step(input logic z, input logic b, input string tag);
        int dotv;
        dotv = 0;
        for (int k = 0; k < 50; k++) dotv += int'(xv[k]) * int'(wv[k]);
        zero   = z;
        isbias = b;
        model_acc = z ? dotv : model_acc + dotv;
        if (b) exp_q.push_back(act(model_acc));
        @(posedge clk);
        #1;
        check({tag, "_acc"}, int'(dut.acc_reg), model_acc);
        if (b) begin
            model_out = exp_q.pop_front();
            check({tag, "_out"}, int'(output_data), model_out);
        end else begin
            check({tag, "_hold"}, int'(output_data), model_out);
        end
        zero   = 1'b0;
        isbias = 1'b0;
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; isbias = 1'b0;
        clear_lanes();
        #1;
        check("rst_out", int'(output_data), 0);
        check("rst_acc", int'(dut.acc_reg), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // B: 1.0 * 0.5 -> acc 2048, then an empty bias chunk -> result 32.
        xv[0] = 8'sd64; wv[0] = 8'sd32;
        step(1'b1, 1'b0, "B_load");
        clear_lanes();
        step(1'b0, 1'b1, "B_bias");

        // A: asynchronous reset between edges clears both at once.
        #2 reset = 1'b1;
        #1;
        check("A_out", int'(output_data), 0);
        check("A_acc", int'(dut.acc_reg), 0);
        model_acc = 0; model_out = 0;
        @(negedge clk); reset = 1'b0;

        // After reset, no zero strobe: accumulate onto 0; bias in lane 50.
        xv[0] = 8'sd64; wv[0] = 8'sd10;
        step(1'b0, 1'b0, "R_nozero");
        clear_lanes();
        xv[49] = 8'sd64; wv[49] = 8'sd5;
        step(1'b0, 1'b1, "R_bias");

        // C: negative sum is clamped to 0.
        clear_lanes();
        xv[0] = 8'sd64; wv[0] = -8'sd32;
        step(1'b1, 1'b0, "C_load");
        clear_lanes();
        step(1'b0, 1'b1, "C_bias");

        // D: 21 chunks of 1.0*1 -> acc 1344, result 21.
        clear_lanes();
        xv[0] = 8'sd64; wv[0] = 8'sd1;
        for (int c = 0; c < 21; c++) step(c == 0, c == 20, "D_chunk");
        check("D_acc_abs", int'(dut.acc_reg), 1344);
        check("D_out_abs", int'(output_data), 21);

        // F: ten random non-bias edges must leave the result at 21.
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 50; k++) begin
                xv[k] = 8'($urandom);
                wv[k] = 8'($urandom);
            end
            step(1'($urandom), 1'b0, "F_rand");
        end
        check("F_out_abs", int'(output_data), 21);

        // Random multi-lane neuron with the bias carried in the last chunk.
        for (int k = 0; k < 50; k++) begin
            xv[k] = 8'($urandom_range(0, 40));
            wv[k] = 8'($urandom_range(0, 20));
        end
        step(1'b1, 1'b0, "M_load");
        for (int k = 0; k < 50; k++) begin
            xv[k] = 8'($urandom_range(0, 10));
            wv[k] = -8'($urandom_range(0, 10));
        end
        xv[49] = 8'sd64; wv[49] = 8'sd100;
        step(1'b0, 1'b1, "M_bias");

        // E: zero and isbias together, every lane at 127*127 -> saturated 127.
        for (int k = 0; k < 50; k++) begin
            xv[k] = 8'sd127;
            wv[k] = 8'sd127;
        end
        step(1'b1, 1'b1, "E_sat");
        check("E_out_abs", int'(output_data), 127);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_neural
